score_display: RTL and testbench
================================

# score_display

Downstream consumer of the collision detector's score/lives outputs and the top-level high-score register. It converts the 16-bit binary current score and high score to 4-digit decimal with a sequential double-dabble engine, then drives the eight active-low 7-segment digits: HEX3..HEX0 show the score and HEX7..HEX4 show the high score. Lives go out as a thermometer LED code, and the score digits blink while the game is over.

## Interface
Parameters:
- BLINK_DIV, 25_000_000: iCLK cycles per blink half-period while game_over is high.

Ports:
- iCLK  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- score  in  16  current score, binary.
- high_score  in  16  best score, binary.
- lives  in  2  remaining lives, 0..3.
- game_over  in  1  level; high when lives are exhausted.
- HEX0..HEX7  out  7 each  segment drive, active-low, bit0=a … bit6=g; HEX0 is the score ones digit and HEX4 is the high-score ones digit.
- led_lives  out  3  thermometer code of lives.

## Operation
- Saturation: any input value greater than 9999 is clamped to 9999 before conversion. The clamped value fits in 14 bits.
- FSM states are IDLE, LOAD, SHIFT and COMMIT.
  - IDLE → LOAD when {score, high_score} ≠ the last committed snapshot, or when the pending flag is set.
  - LOAD: latch the clamped score and high score into shift registers, clear both BCD accumulators (16 bits each), clear the pending flag, and set shift count = 0.
  - SHIFT runs for 14 cycles. In each cycle, add 3 to every BCD nibble ≥ 5, then shift {BCD, bin} left by 1. Both values convert in parallel.
  - COMMIT: copy the BCD results to the digit registers, record the snapshot, and return to IDLE.
- Input changes during LOAD, SHIFT or COMMIT are ignored. The mismatch is detected in the next IDLE cycle.
- Leading-zero blanking applies to each 4-digit group independently. A digit is blanked if it and every higher digit in its group are 0. The ones digit is never blanked, so a value of 0 displays as a single "0".
- Digits 0–9 use standard encodings. Example: 0 = 7'b1000000, 8 = 7'b0000000, blank = 7'b1111111.
- Blink:
  - A free-running counter toggles blink_phase every BLINK_DIV cycles while game_over = 1.
  - When blink_phase = 1, HEX3..HEX0 are forced blank. HEX7..HEX4 are unaffected.
  - When game_over = 0, the counter and phase are held at 0.
- led_lives is registered: lives 0 → 000, 1 → 001, 2 → 011, 3 → 111.

## Timing
- Reset values:
  - All HEX outputs = 7'h7F (blank).
  - led_lives = 000.
  - Digit registers and snapshot = 0, state = IDLE, pending = 1, blink counter and phase = 0.
- Latency: input change sampled in IDLE at edge N. LOAD occupies edge N+1, SHIFT edges N+2..N+15, COMMIT edge N+16. HEX outputs are registered and change at edge N+17.
- After reset is released, pending = 1 forces one conversion, so "0" appears on HEX0 and HEX4 17 cycles later.
- Back-to-back changes: the worst-case update delay is 34 cycles. Intermediate values may be skipped, but the final stable value is always displayed.
- led_lives updates 1 cycle after a change in lives.
- Blink phase toggles exactly every BLINK_DIV cycles. When game_over deasserts, the next edge restores the score digits.
- Reset asserted mid-conversion aborts immediately: outputs go blank, and a fresh conversion starts after release.

## Structure
- The shared package holds:
  - segment constants SEG_BLANK and SEG_DIGIT[0:9];
  - state encoding;
  - MAX_DISPLAY = 9999;
  - CONV_BITS = 14.
- One combinational sub-module, hex_seg_decode, maps a BCD nibble plus a blank flag to 7 segments. It is instantiated 8 times.
- The conversion FSM and the blink logic stay in score_display.

## Test plan
- Reset, then release with all inputs 0 → HEX0 and HEX4 = 7'b1000000 and all other digits blank at cycle 17. Outputs are all blank before that cycle.
- score = 1234, high_score = 56 → after 17 cycles, HEX3..HEX0 show 1,2,3,4; HEX5, HEX4 show 5,6; HEX7, HEX6 are blank.
- score = 16'hFFFF → HEX3..HEX0 show 9,9,9,9 (saturation).
- Change score from 10 to 11 on the cycle after LOAD → 10 displays first, then 11 appears by 34 cycles after the first change.
- game_over = 1 with BLINK_DIV = 4 → score digits blank for 4 cycles and show for 4 cycles, alternating; high-score digits stay steady. Dropping game_over restores the score digits on the next edge.
- lives 3 → 2 → 0 → led_lives 111 → 011 → 000, each 1 cycle after the change. Asserting reset mid-SHIFT blanks all HEX outputs asynchronously.

Source files
------------

// File: rtl/score_display_pkg.sv
// Shared constants, state encoding and helpers for the score/high-score display.
// Segment patterns are active-low with bit0 = a through bit6 = g.
package score_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    localparam logic [15:0] MAX_DISPLAY = 16'd9999;
    localparam int          CONV_BITS   = 14;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        COMMIT
    } conv_state_t;

    // 9999 needs only 14 bits, so the clamped value is truncated to CONV_BITS.
    function automatic logic [CONV_BITS-1:0] clamp_display(input logic [15:0] value);
        logic [15:0] clamped;
        clamped = (value > MAX_DISPLAY) ? MAX_DISPLAY : value;
        return clamped[CONV_BITS-1:0];
    endfunction

    // Double-dabble correction step: +3 on every nibble that is 5 or more.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
        logic [15:0] result;
        result = bcd;
        for (int i = 0; i < 4; i++) begin
            if (result[i*4 +: 4] >= 4'd5) begin
                result[i*4 +: 4] = result[i*4 +: 4] + 4'd3;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/score_display_hex_seg_decode.sv
// Combinational BCD-nibble to active-low 7-segment decoder with a blank override.
// Non-decimal nibbles also show blank.
module hex_seg_decode
    import score_display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank && (bcd <= 4'd9)) begin
            seg = SEG_DIGIT[bcd];
        end
    end

endmodule

// File: rtl/score_display.sv
// Converts score and high score to decimal with a sequential double-dabble engine and
// drives eight 7-segment digits, a lives thermometer and a game-over blink on the score.
module score_display
    import score_display_pkg::*;
#(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic        iCLK,
    input  logic        reset,
    input  logic [15:0] score,
    input  logic [15:0] high_score,
    input  logic [1:0]  lives,
    input  logic        game_over,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7,
    output logic [2:0]  led_lives
);

    localparam int              CNT_W      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [3:0]      SHIFT_LAST = 4'(CONV_BITS - 1);

    conv_state_t state_reg, state_next;

    logic                 pending_reg;
    logic [31:0]          snapshot_reg;
    logic [31:0]          latched_reg;
    logic [CONV_BITS-1:0] score_bin_reg, high_bin_reg;
    logic [15:0]          score_bcd_reg, high_bcd_reg;
    logic [3:0]           shift_cnt_reg;
    logic [15:0]          score_digits_reg, high_digits_reg;
    logic                 digits_valid_reg;

    logic [CNT_W-1:0]     blink_cnt_reg;
    logic                 blink_phase_reg;

    logic [31:0]          digit_vec;
    logic [7:0]           blank_vec;
    logic                 lead_zero;
    logic [55:0]          seg_vec;
    logic [55:0]          hex_reg;
    logic [2:0]           led_lives_reg;

    always_ff @(posedge iCLK or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pending_reg || ({score, high_score} != snapshot_reg)) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (shift_cnt_reg == SHIFT_LAST) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The snapshot records the raw inputs that were converted, so a change that
    // arrives mid-conversion still mismatches in the following IDLE cycle.
    always_ff @(posedge iCLK or posedge reset) begin
        if (reset) begin
            pending_reg      <= 1'b1;
            snapshot_reg     <= '0;
            latched_reg      <= '0;
            score_bin_reg    <= '0;
            high_bin_reg     <= '0;
            score_bcd_reg    <= '0;
            high_bcd_reg     <= '0;
            shift_cnt_reg    <= '0;
            score_digits_reg <= '0;
            high_digits_reg  <= '0;
            digits_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    score_bin_reg <= clamp_display(score);
                    high_bin_reg  <= clamp_display(high_score);
                    latched_reg   <= {score, high_score};
                    score_bcd_reg <= '0;
                    high_bcd_reg  <= '0;
                    pending_reg   <= 1'b0;
                    shift_cnt_reg <= '0;
                end
                SHIFT: begin
                    {score_bcd_reg, score_bin_reg} <= {bcd_adjust(score_bcd_reg), score_bin_reg} << 1;
                    {high_bcd_reg, high_bin_reg}   <= {bcd_adjust(high_bcd_reg), high_bin_reg} << 1;
                    shift_cnt_reg <= shift_cnt_reg + 4'd1;
                end
                COMMIT: begin
                    score_digits_reg <= score_bcd_reg;
                    high_digits_reg  <= high_bcd_reg;
                    snapshot_reg     <= latched_reg;
                    digits_valid_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLK or posedge reset) begin
        if (reset) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (!game_over) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= ~blink_phase_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
    end

    assign digit_vec = {high_digits_reg, score_digits_reg};

    // Leading-zero blanking per group; ones digits only blank for blink or before
    // the first conversion completes. game_over is used directly so dropping it
    // restores the score on the very next edge.
    always_comb begin
        blank_vec = '0;
        lead_zero = 1'b1;
        for (int g = 0; g < 2; g++) begin
            lead_zero = 1'b1;
            for (int d = 3; d >= 1; d--) begin
                lead_zero = lead_zero && (digit_vec[g*16 + d*4 +: 4] == 4'd0);
                blank_vec[g*4 + d] = lead_zero;
            end
        end
        if (!digits_valid_reg) begin
            blank_vec = '1;
        end
        if (game_over && blink_phase_reg) begin
            blank_vec[3:0] = 4'hF;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            hex_seg_decode u_decode (
                .bcd   (digit_vec[gi*4 +: 4]),
                .blank (blank_vec[gi]),
                .seg   (seg_vec[gi*7 +: 7])
            );
        end
    endgenerate

    always_ff @(posedge iCLK or posedge reset) begin
        if (reset) begin
            hex_reg <= {8{SEG_BLANK}};
        end else begin
            hex_reg <= seg_vec;
        end
    end

    always_ff @(posedge iCLK or posedge reset) begin
        if (reset) begin
            led_lives_reg <= 3'b000;
        end else begin
            case (lives)
                2'd0:    led_lives_reg <= 3'b000;
                2'd1:    led_lives_reg <= 3'b001;
                2'd2:    led_lives_reg <= 3'b011;
                default: led_lives_reg <= 3'b111;
            endcase
        end
    end

    assign HEX0      = hex_reg[6:0];
    assign HEX1      = hex_reg[13:7];
    assign HEX2      = hex_reg[20:14];
    assign HEX3      = hex_reg[27:21];
    assign HEX4      = hex_reg[34:28];
    assign HEX5      = hex_reg[41:35];
    assign HEX6      = hex_reg[48:42];
    assign HEX7      = hex_reg[55:49];
    assign led_lives = led_lives_reg;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: expected displays are pushed to a scoreboard
// when stimulus is driven and popped when the registered outputs are sampled.
module tb_score_display;

    localparam logic [55:0] ALL_BLANK = {8{7'h7F}};

    logic        iCLK = 1'b0;
    logic        reset;
    logic [15:0] score;
    logic [15:0] high_score;
    logic [1:0]  lives;
    logic        game_over;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
    logic [2:0]  led_lives;
    logic [55:0] hex_all;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [55:0] exp_q[$];
    logic [2:0]  led_q[$];

    always #5 iCLK = ~iCLK;

    score_display #(.BLINK_DIV(4)) dut (
        .iCLK       (iCLK),
        .reset      (reset),
        .score      (score),
        .high_score (high_score),
        .lives      (lives),
        .game_over  (game_over),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .HEX4       (HEX4),
        .HEX5       (HEX5),
        .HEX6       (HEX6),
        .HEX7       (HEX7),
        .led_lives  (led_lives)
    );

    assign hex_all = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [27:0] group_of(input logic [15:0] v);
        int          x;
        int          digs[4];
        bit          lead;
        logic [27:0] r;
        x = (v > 16'd9999) ? 9999 : int'(v);
        digs[0] = x % 10;
        digs[1] = (x / 10) % 10;
        digs[2] = (x / 100) % 10;
        digs[3] = x / 1000;
        lead = 1'b1;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            lead = lead && (digs[i] == 0) && (i != 0);
            r[i*7 +: 7] = lead ? 7'h7F : seg_of(digs[i]);
        end
        return r;
    endfunction

    function automatic logic [55:0] exp_hex(input logic [15:0] s, input logic [15:0] h, input bit s_off);
        logic [55:0] r;
        r[27:0]  = s_off ? {4{7'h7F}} : group_of(s);
        r[55:28] = group_of(h);
        return r;
    endfunction

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic check_hex(input string tag);
        logic [55:0] e;
        e = exp_q.pop_front();
        n_cmp++;
        assert (hex_all === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, hex_all, e);
        end
    endtask

    task automatic check_led(input string tag);
        logic [2:0] e;
        e = led_q.pop_front();
        n_cmp++;
        assert (led_lives === e) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, led_lives, e);
        end
    endtask

    // DUT must be idle on entry: old display holds through 17 edges, new one on the 18th.
    task automatic convert(input logic [15:0] s, input logic [15:0] h, input string tag);
        exp_q.push_back(exp_hex(score, high_score, 1'b0));
        score      = s;
        high_score = h;
        exp_q.push_back(exp_hex(s, h, 1'b0));
        repeat (17) tick();
        check_hex({tag, "_hold"});
        tick();
        check_hex(tag);
    endtask

    initial begin
        reset      = 1'b1;
        score      = '0;
        high_score = '0;
        lives      = 2'd0;
        game_over  = 1'b0;
        repeat (3) tick();
        exp_q.push_back(ALL_BLANK);
        check_hex("reset_blank");
        led_q.push_back(3'b000);
        check_led("reset_led");

        reset = 1'b0;
        exp_q.push_back(ALL_BLANK);
        exp_q.push_back(exp_hex(16'd0, 16'd0, 1'b0));
        repeat (17) tick();
        check_hex("first_conv_hold");
        tick();
        check_hex("first_conv_zero");

        convert(16'd1234,  16'd56,    "s1234_h56");
        convert(16'hFFFF,  16'd56,    "sat_score");
        convert(16'd1005,  16'd700,   "inner_zero");
        convert(16'd7,     16'd10000, "sat_high");

        // Change lands during SHIFT: 10 shows first, then 11 follows.
        score = 16'd10;
        exp_q.push_back(exp_hex(16'd10, high_score, 1'b0));
        repeat (2) tick();
        score = 16'd11;
        exp_q.push_back(exp_hex(16'd11, high_score, 1'b0));
        repeat (16) tick();
        check_hex("late_first_10");
        for (int i = 0; i < 17 && hex_all !== exp_q[0]; i++) tick();
        check_hex("late_final_11");

        game_over = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            exp_q.push_back(exp_hex(score, high_score, (((k - 1) / 4) % 2) == 1));
        end
        for (int k = 1; k <= 14; k++) begin
            tick();
            check_hex($sformatf("blink_%0d", k));
        end
        game_over = 1'b0;
        exp_q.push_back(exp_hex(score, high_score, 1'b0));
        tick();
        check_hex("blink_restore");
        exp_q.push_back(exp_hex(score, high_score, 1'b0));
        tick();
        check_hex("blink_steady");

        lives = 2'd3; led_q.push_back(3'b111); tick(); check_led("lives_3");
        lives = 2'd2; led_q.push_back(3'b011); tick(); check_led("lives_2");
        lives = 2'd0; led_q.push_back(3'b000); tick(); check_led("lives_0");
        lives = 2'd1; led_q.push_back(3'b001); tick(); check_led("lives_1");

        lives = 2'd2;
        tick();
        score      = 16'd4321;
        high_score = 16'd8765;
        repeat (6) tick();
        #2 reset = 1'b1;
        #1;
        exp_q.push_back(ALL_BLANK);
        check_hex("async_reset_hex");
        led_q.push_back(3'b000);
        check_led("async_reset_led");
        tick();
        reset = 1'b0;
        exp_q.push_back(ALL_BLANK);
        exp_q.push_back(exp_hex(16'd4321, 16'd8765, 1'b0));
        repeat (17) tick();
        check_hex("post_reset_hold");
        tick();
        check_hex("post_reset_conv");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
